// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data memory behind a valid/ready request channel and a
// valid/ready response channel. One request is processed at a time. An
// accepted request waits LATENCY clock edges before the access is performed.
// The response is then held until the initiator accepts it.
//
// Parameters
//   SIZE        data and address width in bits
//   DEPTH       number of SIZE-bit words stored (at least 2)
//   LATENCY     access delay in clock edges, legal range 1..15
//   DEBUG_INDEX word index mirrored on debug_word
//
// Ports
//   clk         single clock; all state updates on its rising edge
//   rst         synchronous, active-high reset
//   req_valid   initiator presents a request
//   req_ready   responder can accept a request (high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_addr    byte address; word index is req_addr[$clog2(DEPTH)+1:2]
//   req_wdata   store data
//   resp_valid  response available
//   resp_ready  initiator accepts the response
//   resp_rdata  load data (zero for stores and errors)
//   resp_err    request was misaligned or out of range
//   txn_count   count of completed response handshakes, wraps at 16 bits
//   debug_word  combinational copy of mem[DEBUG_INDEX]
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int SIZE        = 32,
    parameter int DEPTH       = 16,
    parameter int LATENCY     = 2,
    parameter int DEBUG_INDEX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic [15:0]     txn_count,
    output logic [SIZE-1:0] debug_word
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int WA_W  = SIZE - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [SIZE-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       txn_q, txn_d;

    // Captured request; only meaningful while in WAIT, so it carries no reset.
    logic              we_q;
    logic [SIZE-1:0]   addr_q;
    logic [SIZE-1:0]   wdata_q;

    logic [SIZE-1:0]   mem_q [DEPTH];

    logic              capture;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic              bad_addr;

    // Misaligned, or the full word address (not just the index bits) falls
    // beyond the array. Checking the full address keeps aliased high
    // addresses from silently hitting a low word.
    function automatic logic addr_bad(input logic [SIZE-1:0] a);
        logic [WA_W-1:0] wa;
        wa = a[SIZE-1:2];
        return (a[1:0] != 2'b00) || (wa >= WA_W'(DEPTH));
    endfunction

    assign idx      = addr_q[IDX_W+1:2];
    assign bad_addr = addr_bad(addr_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        txn_d    = txn_q;
        capture  = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The edge that sees cnt == 1 is the LATENCY-th edge after
                // acceptance; the access happens on it.
                if (cnt_q == 4'd1) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    if (bad_addr) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (we_q) begin
                            mem_we  = 1'b1;
                            rdata_d = '0;
                        end else begin
                            rdata_d = mem_q[idx];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Response fields hold until this handshake; returning to
                // IDLE here means the next request lands one cycle later.
                if (resp_ready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    txn_d    = txn_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            txn_q    <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SIZE'(i);
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            txn_q    <= txn_d;
            if (mem_we) begin
                mem_q[idx] <= wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign txn_count  = txn_q;
    assign debug_word = mem_q[DEBUG_INDEX];

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share the request/response inputs: dut_a (LATENCY=2) and
// dut_b (LATENCY=1). The sel signal gates req_valid to one of them and picks
// which one's outputs are observed. Expected responses are queued as each
// request is issued, and a negedge monitor pops and compares them on every
// response handshake.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_resp_rdata, a_debug_word;
    logic [15:0] a_txn_count;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata, b_debug_word;
    logic [15:0] b_txn_count;

    logic        a_req_valid, b_req_valid;
    logic        m_req_ready, m_resp_valid, m_resp_err;
    logic [31:0] m_resp_rdata, m_debug_word;
    logic [15:0] m_txn_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    assign a_req_valid  = req_valid & ~sel;
    assign b_req_valid  = req_valid & sel;
    assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign m_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    assign m_debug_word = sel ? b_debug_word : a_debug_word;
    assign m_txn_count  = sel ? b_txn_count  : a_txn_count;

    dmem_responder #(.SIZE(32), .DEPTH(16), .LATENCY(2), .DEBUG_INDEX(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .txn_count(a_txn_count), .debug_word(a_debug_word)
    );

    dmem_responder #(.SIZE(32), .DEPTH(16), .LATENCY(1), .DEBUG_INDEX(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .txn_count(b_txn_count), .debug_word(b_debug_word)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a handshake seen at negedge completes on the next edge.
    always @(negedge clk) begin
        if (!rst && m_resp_valid && resp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got rdata 0x%08h err %0b, expected no response",
                         m_resp_rdata, m_resp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if (m_resp_err !== e[32] || m_resp_rdata !== e[31:0]) begin
                    n_bad++;
                    $display("FAIL resp: got rdata 0x%08h err %0b, expected rdata 0x%08h err %0b",
                             m_resp_rdata, m_resp_err, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!m_req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_wait", 32'(m_req_ready), 32'd1);
    endtask

    // Issue one request; returns when resp_valid is seen (hs=0) or after
    // the handshake edge (hs=1, resp_ready assumed high).
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input logic hs, output time t_acc);
        int n;
        wait_ready();
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        t_acc = $time;
        #1 req_valid = 1'b0;
        n = 0;
        while (!m_resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("req_ready_busy", 32'(m_req_ready), 32'd0);
        if (hs) begin
            @(posedge clk);
            #1;
            check("resp_valid_cleared", 32'(m_resp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time         t0, t1;
        logic [31:0] hold_d;
        logic        hold_e;

        sel        = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_req_ready", 32'(m_req_ready), 32'd1);
        check("rst_resp_valid", 32'(m_resp_valid), 32'd0);
        check("rst_rdata", m_resp_rdata, 32'd0);
        check("rst_err", 32'(m_resp_err), 32'd0);
        check("rst_txn", 32'(m_txn_count), 32'd0);
        check("rst_debug", m_debug_word, 32'd4);

        // Basic load of word 4
        txn(1'b0, 32'h10, 32'h0, 32'h4, 1'b0, 2, 1'b1, t0);
        check("txn_after_load", 32'(m_txn_count), 32'd1);

        // Store then load back the same word; debug_word mirrors word 4
        do_reset();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, t0);
        check("debug_after_store", m_debug_word, 32'hDEADBEEF);
        txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, t0);
        check("txn_after_store_load", 32'(m_txn_count), 32'd2);

        // Backpressure: response held for 5 cycles, stray request ignored
        resp_ready = 1'b0;
        txn(1'b0, 32'h14, 32'h0, 32'h5, 1'b0, 2, 1'b0, t0);
        hold_d = m_resp_rdata;
        hold_e = m_resp_err;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                req_we    = 1'b1;
                req_addr  = 32'h0C;
                req_wdata = 32'h00000BAD;
                req_valid = 1'b1;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            check("hold_valid", 32'(m_resp_valid), 32'd1);
            check("hold_rdata", m_resp_rdata, hold_d);
            check("hold_err", 32'(m_resp_err), 32'(hold_e));
            check("hold_req_ready", 32'(m_req_ready), 32'd0);
        end
        check("hold_txn", 32'(m_txn_count), 32'd2);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_txn_release", 32'(m_txn_count), 32'd3);
        check("hold_valid_release", 32'(m_resp_valid), 32'd0);
        txn(1'b0, 32'h0C, 32'h0, 32'h3, 1'b0, 2, 1'b1, t0);

        // Error cases: misaligned and out of range, loads and stores
        txn(1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 2, 1'b1, t0);
        txn(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 2, 1'b1, t0);
        txn(1'b1, 32'h44, 32'h11111111, 32'h0, 1'b1, 2, 1'b1, t0);
        txn(1'b1, 32'h06, 32'h22222222, 32'h0, 1'b1, 2, 1'b1, t0);
        txn(1'b1, 32'h10000004, 32'h33333333, 32'h0, 1'b1, 2, 1'b1, t0);
        txn(1'b0, 32'h04, 32'h0, 32'h1, 1'b0, 2, 1'b1, t0);
        check("txn_after_errors", 32'(m_txn_count), 32'd10);

        // Reset one edge after accepting a store discards it
        do_reset();
        wait_ready();
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_wdata = 32'h00001234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rstwait_req_ready", 32'(m_req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rstwait_resp_valid", 32'(m_resp_valid), 32'd0);
        check("rstwait_txn", 32'(m_txn_count), 32'd0);
        txn(1'b0, 32'h08, 32'h0, 32'h2, 1'b0, 2, 1'b1, t0);

        // LATENCY=1 instance: one-edge latency and three-cycle spacing
        do_reset();
        sel = 1'b1;
        #1;
        check("b_rst_req_ready", 32'(m_req_ready), 32'd1);
        txn(1'b1, 32'h20, 32'hCAFE0001, 32'h0, 1'b0, 1, 1'b1, t0);
        txn(1'b0, 32'h20, 32'h0, 32'hCAFE0001, 1'b0, 1, 1'b1, t1);
        check("b_spacing", 32'(t1 - t0), 32'd30);
        check("b_txn", 32'(m_txn_count), 32'd2);

        @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
